// File: rtl/ysyx_24070014_arb_pkg.sv
// ysyx_24070014_arb_pkg: shared FSM states and master ids for the memory arbiter
package ysyx_24070014_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;
endpackage

// File: rtl/ysyx_24070014_arb_grant.sv
// ysyx_24070014_arb_grant: combinational winner select between IFU and LSU
// YSYX_24070014_ARB_RR_EN selects round-robin on contention; otherwise LSU has fixed priority
module ysyx_24070014_arb_grant
  import ysyx_24070014_arb_pkg::*;
(
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
`ifdef YSYX_24070014_ARB_RR_EN
  input  logic ptr_i,
`endif
  output logic gnt_valid_o,
  output logic gnt_id_o
);
  assign gnt_valid_o = ifu_valid_i | lsu_valid_i;
`ifdef YSYX_24070014_ARB_RR_EN
  assign gnt_id_o = (ifu_valid_i & lsu_valid_i) ? ptr_i : (lsu_valid_i ? MST_LSU : MST_IFU);
`else
  assign gnt_id_o = lsu_valid_i ? MST_LSU : MST_IFU;
`endif
endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// ysyx_24070014_mem_arbiter: shares one memory bridge port between IFU and LSU, one transaction at a time
// YSYX_24070014_ARB_RR_EN enables round-robin arbitration with a pointer flop
module ysyx_24070014_mem_arbiter
  import ysyx_24070014_arb_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                ifu_resp_valid_q, ifu_resp_valid_d;
  logic                lsu_resp_valid_q, lsu_resp_valid_d;
  logic                gnt_valid, gnt_id, lsu_win, mem_done, resp_done;
`ifdef YSYX_24070014_ARB_RR_EN
  logic                ptr_q, ptr_d;
`endif

  ysyx_24070014_arb_grant u_grant (
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
`ifdef YSYX_24070014_ARB_RR_EN
    .ptr_i       (ptr_q),
`endif
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Readies are gated by reset so nothing is accepted while the block is held in reset.
  assign lsu_win       = gnt_id == MST_LSU;
  assign ifu_req_ready = reset & (state_q == IDLE) & gnt_valid & ~lsu_win;
  assign lsu_req_ready = reset & (state_q == IDLE) & gnt_valid & lsu_win;
  assign mem_done      = (state_q == WAIT) ? mem_resp_valid : (mem_req_ready & mem_resp_valid);
  assign resp_done     = (gnt_q == MST_LSU) ? lsu_resp_ready : ifu_resp_ready;

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign ifu_rdata      = rdata_q;
  assign lsu_rdata      = rdata_q;

  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    rdata_d          = rdata_q;
    mem_req_valid_d  = mem_req_valid_q;
    ifu_resp_valid_d = ifu_resp_valid_q;
    lsu_resp_valid_d = lsu_resp_valid_q;
`ifdef YSYX_24070014_ARB_RR_EN
    ptr_d            = ptr_q;
`endif
    unique case (state_q)
      IDLE: if (gnt_valid) begin
        state_d         = ISSUE;
        mem_req_valid_d = 1'b1;
        gnt_d           = gnt_id;
        addr_d          = lsu_win ? lsu_addr : ifu_addr;
        wen_d           = lsu_win & lsu_wen;
        wdata_d         = lsu_win ? lsu_wdata : '0;
        wmask_d         = lsu_win ? lsu_wmask : '0;
`ifdef YSYX_24070014_ARB_RR_EN
        ptr_d           = ~ptr_q;
`endif
      end
      ISSUE, WAIT: begin
        if (state_q == ISSUE && mem_req_ready) begin
          state_d         = WAIT;
          mem_req_valid_d = 1'b0;
        end
        if (mem_done) begin
          state_d          = RESP;
          mem_req_valid_d  = 1'b0;
          rdata_d          = wen_q ? '0 : mem_rdata;
          ifu_resp_valid_d = gnt_q == MST_IFU;
          lsu_resp_valid_d = gnt_q == MST_LSU;
        end
      end
      RESP: if (resp_done) begin
        state_d          = IDLE;
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      gnt_q            <= MST_IFU;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      rdata_q          <= '0;
      mem_req_valid_q  <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
`ifdef YSYX_24070014_ARB_RR_EN
      ptr_q            <= MST_IFU;
`endif
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      rdata_q          <= rdata_d;
      mem_req_valid_q  <= mem_req_valid_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
`ifdef YSYX_24070014_ARB_RR_EN
      ptr_q            <= ptr_d;
`endif
    end
  end
endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// tb_ysyx_24070014_mem_arbiter: random IFU/LSU traffic against a transaction-level model with scoreboards
module tb_ysyx_24070014_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 0;
  logic [31:0] ifu_addr = 0, ifu_rdata;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 0;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
  logic [3:0]  lsu_wmask = 0;
  logic        mem_req_valid, mem_req_ready = 0, mem_wen, mem_resp_valid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;

  ysyx_24070014_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask; logic lsu;} req_t;

  int          tests = 0, fails = 0;
  logic [31:0] bmem [16];
  logic [31:0] shadow [16];
  req_t        req_q [$];
  logic [31:0] ri_q [$], rl_q [$];
  bit          mon_en = 0, ifu_acc = 0, lsu_acc = 0;
  int          m_ph = 0;
  bit          m_who = 0, m_ptr = 0, gi, gl;
  bit          owe = 0, b_wen = 0;
  logic [3:0]  b_idx = 0;
  req_t        r;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Transaction-level reference: idle(0) -> issued(1) -> waiting(2) -> responding(3)
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      gi = 0;
      gl = 0;
      if (m_ph == 0) begin
`ifdef YSYX_24070014_ARB_RR_EN
        if (ifu_req_valid && lsu_req_valid) begin gl = m_ptr; gi = !m_ptr; end
        else begin gi = ifu_req_valid; gl = lsu_req_valid; end
`else
        gl = lsu_req_valid;
        gi = ifu_req_valid && !lsu_req_valid;
`endif
      end
      chk("ifu_req_ready", ifu_req_ready, gi);
      chk("lsu_req_ready", lsu_req_ready, gl);
      chk("mem_req_valid", mem_req_valid, m_ph == 1);
      chk("ifu_resp_valid", ifu_resp_valid, m_ph == 3 && !m_who);
      chk("lsu_resp_valid", lsu_resp_valid, m_ph == 3 && m_who);
      if (m_ph == 1 && req_q.size() > 0) begin
        chk("mem_addr", mem_addr, req_q[0].addr);
        chk("mem_wen", mem_wen, req_q[0].wen);
        chk("mem_wmask", mem_wmask, req_q[0].wmask);
        if (req_q[0].lsu) chk("mem_wdata", mem_wdata, req_q[0].wdata);
      end
      if (m_ph == 3 && !m_who && ri_q.size() > 0) chk("ifu_rdata", ifu_rdata, ri_q[0]);
      if (m_ph == 3 && m_who && rl_q.size() > 0) chk("lsu_rdata", lsu_rdata, rl_q[0]);
      ifu_acc = gi;
      lsu_acc = gl;
      case (m_ph)
        0: if (gi || gl) begin
          r.lsu = gl;
          r.addr = gl ? lsu_addr : ifu_addr;
          r.wen = gl && lsu_wen;
          r.wdata = lsu_wdata;
          r.wmask = gl ? lsu_wmask : 4'h0;
          req_q.push_back(r);
          if (r.wen) begin
            for (int b = 0; b < 4; b++) if (r.wmask[b]) shadow[r.addr[5:2]][8*b +: 8] = r.wdata[8*b +: 8];
            rl_q.push_back(32'h0);
          end else if (gl) rl_q.push_back(shadow[r.addr[5:2]]);
          else ri_q.push_back(shadow[r.addr[5:2]]);
          m_ph = 1;
          m_who = gl;
          m_ptr = !m_ptr;
        end
        1: if (mem_req_ready) begin
          void'(req_q.pop_front());
          m_ph = mem_resp_valid ? 3 : 2;
        end
        2: if (mem_resp_valid) m_ph = 3;
        default: if (m_who ? lsu_resp_ready : ifu_resp_ready) begin
          if (m_who) void'(rl_q.pop_front()); else void'(ri_q.pop_front());
          m_ph = 0;
        end
      endcase
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      bmem[i] = $urandom;
      shadow[i] = bmem[i];
    end
    bmem[0] = 32'h0000_0413;
    shadow[0] = 32'h0000_0413;
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    #1 reset = 0;
    #2;
    chk("rst ifu_req_ready", ifu_req_ready, 0);
    chk("rst lsu_req_ready", lsu_req_ready, 0);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wen", mem_wen, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wmask", mem_wmask, 0);
    chk("rst ifu_rdata", ifu_rdata, 0);
    chk("rst lsu_rdata", lsu_rdata, 0);
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    mon_en = 1;
    repeat (4000) begin
      @(negedge clk);
      if (!ifu_req_valid || ifu_acc) begin
        ifu_req_valid = ($urandom % 3) == 0;
        ifu_addr = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
      end
      if (!lsu_req_valid || lsu_acc) begin
        lsu_req_valid = ($urandom % 3) == 0;
        lsu_addr = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
        lsu_wen = $urandom % 2;
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom);
      end
      ifu_resp_ready = ($urandom % 3) != 0;
      lsu_resp_ready = ($urandom % 3) != 0;
      mem_req_ready = 0;
      mem_resp_valid = 0;
      mem_rdata = $urandom;
      if (owe) begin
        if ($urandom % 2) begin
          mem_resp_valid = 1;
          if (!b_wen) mem_rdata = bmem[b_idx];
          owe = 0;
        end
      end else if (mem_req_valid) begin
        mem_req_ready = $urandom % 2;
        if (mem_req_ready) begin
          if (mem_wen)
            for (int b = 0; b < 4; b++) if (mem_wmask[b]) bmem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          if ($urandom % 2) begin
            mem_resp_valid = 1;
            if (!mem_wen) mem_rdata = bmem[mem_addr[5:2]];
          end else begin
            owe = 1;
            b_wen = mem_wen;
            b_idx = mem_addr[5:2];
          end
        end else mem_resp_valid = ($urandom % 4) == 0;
      end else mem_resp_valid = ($urandom % 8) == 0;
    end
    @(negedge clk);
    mon_en = 0;
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    mem_req_ready = 0;
    mem_resp_valid = 0;
    ifu_resp_ready = 0;
    lsu_resp_ready = 0;
    reset = 0;
    @(negedge clk);
    reset = 1;
    ifu_req_valid = 1;
    ifu_addr = 32'h8000_0000;
    #2;
    chk("dir ifu_req_ready", ifu_req_ready, 1);
    chk("dir lsu_req_ready", lsu_req_ready, 0);
    @(negedge clk);
    ifu_req_valid = 0;
    mem_req_ready = 1;
    #2;
    chk("dir mem_req_valid", mem_req_valid, 1);
    chk("dir mem_addr", mem_addr, 32'h8000_0000);
    chk("dir mem_wmask", mem_wmask, 0);
    @(negedge clk);
    mem_req_ready = 0;
    #2;
    chk("wait mem_req_valid", mem_req_valid, 0);
    chk("wait ifu_resp_valid", ifu_resp_valid, 0);
    #1 reset = 0;
    #1;
    chk("abort mem_req_valid", mem_req_valid, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort ifu_resp_valid", ifu_resp_valid, 0);
    chk("abort ifu_rdata", ifu_rdata, 0);
    @(negedge clk);
    reset = 1;
    mem_resp_valid = 1;
    mem_rdata = 32'h1234;
    @(negedge clk);
    mem_resp_valid = 0;
    #2;
    chk("late ifu_resp_valid", ifu_resp_valid, 0);
    chk("late lsu_resp_valid", lsu_resp_valid, 0);
    chk("late ifu_rdata", ifu_rdata, 0);
    chk("late mem_req_valid", mem_req_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
